// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync receiver: timing lock, pixel coordinates and data enable
//
// Purpose: registers the incoming sync/pixel pins, counts columns and lines from
// the sync edges, measures and verifies line/frame timing, and once locked emits
// the active pixel with its column/row coordinates.
//
// Ports:
//   Clock        pixel clock, all inputs synchronous to it
//   Reset        synchronous, active-high
//   iHsync       horizontal sync (pulse level = SYNC_POL)
//   iVsync       vertical sync   (pulse level = SYNC_POL)
//   iRGB         pixel colour {R,G,B}
//   oRGB         recovered pixel, 0 outside the active region
//   oX, oY       active column/row, 0 when oDE=0
//   oDE          data enable
//   oFrameStart  one-cycle pulse at each applied frame start
//   oLocked      timing locked
//   oSyncErr     sticky: lock lost through a timing mismatch
//   oLineLen     cycles per line, last captured value
//   oFrameLines  lines per frame, last captured value
module vga_sync_receiver #(
    parameter int SYNC_POL = 0,
    parameter int H_BP     = 0,
    parameter int H_ACTIVE = 640,
    parameter int V_BP     = 0,
    parameter int V_ACTIVE = 480
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iHsync,
    input  logic        iVsync,
    input  logic [2:0]  iRGB,
    output logic [2:0]  oRGB,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oDE,
    output logic        oFrameStart,
    output logic        oLocked,
    output logic        oSyncErr,
    output logic [11:0] oLineLen,
    output logic [10:0] oFrameLines
);

    localparam logic        POL  = (SYNC_POL != 0);
    localparam logic [11:0] H_LO = 12'(H_BP);
    localparam logic [11:0] H_HI = 12'(H_BP + H_ACTIVE);
    localparam logic [10:0] V_LO = 11'(V_BP);
    localparam logic [10:0] V_HI = 11'(V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_hs;
    logic        r_hs_d;
    logic        r_vs;
    logic        r_vs_d;
    logic [2:0]  r_rgb;
    logic [11:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic        r_pend;
    logic        r_first;   // next line start ends the first line of the frame
    logic        r_bad;     // a line mismatched during MEASURE/VERIFY

    logic        w_line_start;
    logic        w_frame_edge;
    logic        w_apply_fs;
    logic [11:0] w_hcnt_n;
    logic [10:0] w_vcnt_n;
    logic [11:0] w_line_len;
    logic [10:0] w_frame_lines;
    logic        w_len_ok;
    logic        w_frames_ok;
    logic        w_timeout;
    logic        w_de;

    // Trailing edge of the sync pulse marks the start of a line/frame.
    assign w_line_start  = (r_hs_d == POL) && (r_hs == ~POL);
    assign w_frame_edge  = (r_vs_d == POL) && (r_vs == ~POL);
    // A frame start is applied on a line start, so vcnt always restarts at a line boundary.
    assign w_apply_fs    = w_line_start && (r_pend || w_frame_edge);

    // Counter values that belong to the pixel currently held in r_rgb.
    assign w_hcnt_n      = w_line_start ? 12'd0 :
                           (r_hcnt == 12'hFFF) ? r_hcnt : r_hcnt + 12'd1;
    assign w_vcnt_n      = w_apply_fs ? 11'd0 :
                           (w_line_start && r_vcnt != 11'h7FF) ? r_vcnt + 11'd1 : r_vcnt;

    assign w_line_len    = r_hcnt + 12'd1;
    assign w_frame_lines = r_vcnt + 11'd1;
    assign w_len_ok      = (w_line_len == oLineLen);
    assign w_frames_ok   = (w_frame_lines == oFrameLines);
    assign w_timeout     = (r_hcnt == 12'hFFF) && !w_line_start;

    assign w_de = (r_state == LOCKED)
               && (w_hcnt_n >= H_LO) && (w_hcnt_n < H_HI)
               && (w_vcnt_n >= V_LO) && (w_vcnt_n < V_HI);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= IDLE;
            // Idle level on the sync history so no edge is seen coming out of reset.
            r_hs        <= ~POL;
            r_hs_d      <= ~POL;
            r_vs        <= ~POL;
            r_vs_d      <= ~POL;
            r_rgb       <= '0;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_pend      <= 1'b0;
            r_first     <= 1'b0;
            r_bad       <= 1'b0;
            oRGB        <= '0;
            oX          <= '0;
            oY          <= '0;
            oDE         <= 1'b0;
            oFrameStart <= 1'b0;
            oLocked     <= 1'b0;
            oSyncErr    <= 1'b0;
            oLineLen    <= '0;
            oFrameLines <= '0;
        end else begin
            r_hs   <= iHsync;
            r_hs_d <= r_hs;
            r_vs   <= iVsync;
            r_vs_d <= r_vs;
            r_rgb  <= iRGB;
            r_hcnt <= w_hcnt_n;
            r_vcnt <= w_vcnt_n;

            if (w_apply_fs)
                r_pend <= 1'b0;
            else if (w_frame_edge)
                r_pend <= 1'b1;

            oFrameStart <= w_apply_fs;
            oDE         <= w_de;
            oX          <= w_de ? 10'(w_hcnt_n - H_LO) : 10'd0;
            oY          <= w_de ? 10'(w_vcnt_n - V_LO) : 10'd0;
            oRGB        <= w_de ? r_rgb : 3'd0;

            if (w_timeout) begin
                // Sync has vanished: drop everything but the sticky error.
                r_state <= IDLE;
                oLocked <= 1'b0;
                r_first <= 1'b0;
                r_bad   <= 1'b0;
            end else if (w_line_start) begin
                case (r_state)
                    IDLE: begin
                        if (w_apply_fs) begin
                            r_state <= MEASURE;
                            r_first <= 1'b1;
                            r_bad   <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (w_apply_fs) begin
                            if (r_first || r_bad || !w_len_ok) begin
                                // Unstable frame: measure again from scratch.
                                r_first <= 1'b1;
                                r_bad   <= 1'b0;
                            end else begin
                                oFrameLines <= w_frame_lines;
                                r_state     <= VERIFY;
                            end
                        end else if (r_first) begin
                            oLineLen <= w_line_len;
                            r_first  <= 1'b0;
                        end else if (!w_len_ok) begin
                            r_bad <= 1'b1;
                        end
                    end
                    VERIFY: begin
                        if (w_apply_fs) begin
                            if (!r_bad && w_len_ok && w_frames_ok) begin
                                r_state <= LOCKED;
                                oLocked <= 1'b1;
                            end else begin
                                r_state <= MEASURE;
                                r_first <= 1'b1;
                            end
                            r_bad <= 1'b0;
                        end else if (!w_len_ok) begin
                            r_bad <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        // The captured line length stays valid, so MEASURE can
                        // go straight to capturing frame lines at the next frame start.
                        if (!w_len_ok || (w_apply_fs && !w_frames_ok)) begin
                            r_state  <= MEASURE;
                            oLocked  <= 1'b0;
                            oSyncErr <= 1'b1;
                            r_first  <= 1'b0;
                            r_bad    <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed self-checking bench for vga_sync_receiver
//
// Purpose: drives a scaled-down VGA-like raster (40-cycle lines, 30-line frames)
// and checks lock, pixel mapping, line error, timeout, coincident edges and reset.
// Ports of the DUT are all connected; the bench has none.
module tb_vga_sync_receiver;

    localparam int L      = 40;     // cycles per line
    localparam int HS     = 4;      // hsync pulse width, at the end of each line
    localparam int F      = 30;     // lines per frame
    localparam int FL     = L * F;
    localparam int H_BP   = 4;
    localparam int H_ACT  = 24;
    localparam int V_BP   = 2;
    localparam int V_ACT  = 24;

    logic        Clock;
    logic        Reset;
    logic        iHsync;
    logic        iVsync;
    logic [2:0]  iRGB;
    logic [2:0]  oRGB;
    logic [9:0]  oX;
    logic [9:0]  oY;
    logic        oDE;
    logic        oFrameStart;
    logic        oLocked;
    logic        oSyncErr;
    logic [11:0] oLineLen;
    logic [10:0] oFrameLines;

    vga_sync_receiver #(
        .SYNC_POL (0),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACT),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACT)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iHsync      (iHsync),
        .iVsync      (iVsync),
        .iRGB        (iRGB),
        .oRGB        (oRGB),
        .oX          (oX),
        .oY          (oY),
        .oDE         (oDE),
        .oFrameStart (oFrameStart),
        .oLocked     (oLocked),
        .oSyncErr    (oSyncErr),
        .oLineLen    (oLineLen),
        .oFrameLines (oFrameLines)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_total = 0;
    int n_bad   = 0;

    int t   = 100;          // position within the frame
    int tv  = FL - 10;      // vsync rising position within the frame
    bit stop    = 0;
    bit pixmode = 0;
    bit exp_lock = 0;

    int p_gh = 0, p_gv = 0;
    logic [2:0] p_rgb = 3'd0;

    int st_de, st_miss, st_map, st_leak, fs_cnt, hit_cnt, hit_x, hit_y;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_stats();
        st_de = 0; st_miss = 0; st_map = 0; st_leak = 0;
        fs_cnt = 0; hit_cnt = 0; hit_x = 0; hit_y = 0;
    endtask

    // One clock: drive the inputs for position t, then observe the outputs that
    // belong to the input of the previous call (two-cycle pin-to-pin latency).
    task automatic tick(input bit hold);
        int  gh, gv, pos;
        bit  e_de;
        gh  = t % L;
        gv  = t / L;
        pos = (t - tv + FL) % FL;
        if (stop) begin
            iHsync = 1'b1;
            iVsync = 1'b1;
        end else begin
            iHsync = (gh >= L - HS) ? 1'b0 : 1'b1;
            iVsync = (pos >= FL - 2 * L) ? 1'b0 : 1'b1;
        end
        if (pixmode)
            iRGB = (gh == H_BP + 10 && gv == V_BP + 20) ? 3'b101 : 3'b000;
        else
            iRGB = 3'(gh % 7 + 1);
        @(posedge Clock);
        #1;
        if (oFrameStart) fs_cnt++;
        if (oDE) st_de++;
        if (!oDE && (oX != 0 || oY != 0 || oRGB != 0)) st_leak++;
        if (exp_lock) begin
            e_de = (p_gh >= H_BP) && (p_gh < H_BP + H_ACT) && (p_gv >= V_BP) && (p_gv < V_BP + V_ACT);
            if (e_de != oDE) st_miss++;
            if (oDE && (int'(oX) != p_gh - H_BP || int'(oY) != p_gv - V_BP || oRGB != p_rgb)) st_map++;
        end
        if (pixmode && oRGB == 3'b101) begin
            hit_cnt++;
            hit_x = int'(oX);
            hit_y = int'(oY);
        end
        p_gh  = gh;
        p_gv  = gv;
        p_rgb = iRGB;
        if (!hold) t = (t + 1) % FL;
    endtask

    // Advance until the next frame start has been presented and its effect is visible.
    task automatic goto_fs();
        while (t != 0) tick(1'b0);
        tick(1'b0);
        tick(1'b0);
    endtask

    initial begin
        Reset = 1'b1; iHsync = 1'b1; iVsync = 1'b1; iRGB = 3'd0;
        clear_stats();
        repeat (3) tick(1'b0);
        chk("rst_locked",  32'(oLocked), 0);
        chk("rst_de",      32'(oDE), 0);
        chk("rst_linelen", 32'(oLineLen), 0);
        chk("rst_syncerr", 32'(oSyncErr), 0);
        Reset = 1'b0;

        // Lock sequence: IDLE -> MEASURE -> VERIFY -> LOCKED over three frame starts.
        goto_fs();
        chk("fs1_pulse",   32'(oFrameStart), 1);
        chk("fs1_locked",  32'(oLocked), 0);
        goto_fs();
        chk("fs2_locked",  32'(oLocked), 0);
        chk("linelen",     32'(oLineLen), L);
        chk("framelines",  32'(oFrameLines), F);
        goto_fs();
        chk("fs3_locked",  32'(oLocked), 1);

        // One full locked frame of varied pixels.
        clear_stats();
        exp_lock = 1;
        repeat (FL) tick(1'b0);
        chk("frame_de_count", st_de, H_ACT * V_ACT);
        chk("frame_de_miss",  st_miss, 0);
        chk("frame_map",      st_map, 0);
        chk("frame_leak",     st_leak, 0);
        chk("frame_fs_count", fs_cnt, 1);

        // Single marked pixel at column 10, row 20.
        clear_stats();
        pixmode = 1;
        repeat (FL) tick(1'b0);
        chk("pix_hits", hit_cnt, 1);
        chk("pix_x",    hit_x, 10);
        chk("pix_y",    hit_y, 20);
        chk("pix_map",  st_map, 0);
        pixmode = 0;
        exp_lock = 0;

        // Line error: one 41-cycle line while locked.
        while (t != 5 * L + 5) tick(1'b0);
        tick(1'b1);
        while (t != 6 * L + 2) tick(1'b0);
        chk("lerr_locked",  32'(oLocked), 0);
        chk("lerr_syncerr", 32'(oSyncErr), 1);
        chk("lerr_state",   32'(dut.r_state), 1);
        goto_fs();
        chk("lerr_verify",  32'(dut.r_state), 2);
        goto_fs();
        chk("relock",         32'(oLocked), 1);
        chk("relock_syncerr", 32'(oSyncErr), 1);

        // Coincident hsync and vsync edges.
        tv = 0;
        while (t != 0) tick(1'b0);
        fs_cnt = 0;
        tick(1'b0);
        tick(1'b0);
        chk("coin_pulse", 32'(oFrameStart), 1);
        chk("coin_vcnt",  32'(dut.r_vcnt), 0);
        chk("coin_pend",  32'(dut.r_pend), 0);
        while (t != L + 2) tick(1'b0);
        chk("coin_fs_count", fs_cnt, 1);
        chk("coin_locked",   32'(oLocked), 1);

        // Timeout: sync edges stop while locked.
        stop = 1;
        repeat (4000) tick(1'b1);
        chk("to_before",  32'(oLocked), 1);
        repeat (150) tick(1'b1);
        chk("to_locked",  32'(oLocked), 0);
        chk("to_state",   32'(dut.r_state), 0);
        chk("to_syncerr", 32'(oSyncErr), 1);
        stop = 0;

        goto_fs();
        goto_fs();
        goto_fs();
        chk("to_relock", 32'(oLocked), 1);

        // Mid-frame reset inside the active region.
        while (t != 500) tick(1'b0);
        Reset = 1'b1;
        tick(1'b0);
        Reset = 1'b0;
        chk("mr_locked",     32'(oLocked), 0);
        chk("mr_syncerr",    32'(oSyncErr), 0);
        chk("mr_de",         32'(oDE), 0);
        chk("mr_x",          32'(oX), 0);
        chk("mr_y",          32'(oY), 0);
        chk("mr_rgb",        32'(oRGB), 0);
        chk("mr_linelen",    32'(oLineLen), 0);
        chk("mr_framelines", 32'(oFrameLines), 0);
        chk("mr_fs",         32'(oFrameStart), 0);
        goto_fs();
        chk("mr_fs1_locked", 32'(oLocked), 0);
        goto_fs();
        chk("mr_fs2_locked", 32'(oLocked), 0);
        goto_fs();
        chk("mr_fs3_locked", 32'(oLocked), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SYNC_POL, 0, level of the sync pulse on iHsync/iVsync (0 = pulse is low).
- H_BP, 0, cycles from line start to first active pixel.
- H_ACTIVE, 640, active pixels per line (max 1023).
- V_BP, 0, lines from frame start to first active line.
- V_ACTIVE, 480, active lines per frame (max 1023).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clock, in, 1, pixel clock; all inputs are synchronous to it.
- Reset, in, 1, synchronous, active-high.
- iHsync, in, 1, horizontal sync.
- iVsync, in, 1, vertical sync.
- iRGB, in, 3, pixel colour {R,G,B}.
- oRGB, out, 3, recovered pixel; 0 outside the active region.
- oX, out, 10, active column; 0 when oDE=0.
- oY, out, 10, active row; 0 when oDE=0.
- oDE, out, 1, data enable.
- oFrameStart, out, 1, one-cycle pulse at each applied frame start.
- oLocked, out, 1, timing locked.
- oSyncErr, out, 1, sticky: lock was lost because of a mismatch.
- oLineLen, out, 12, cycles per line, last captured value.
- oFrameLines, out, 11, lines per frame, last captured value.

Function
REQ-003 iHsync, iVsync and iRGB SHALL be registered once; edge detection SHALL use the registered value against its one-cycle-delayed copy.
REQ-004 Line start SHALL be a transition from level SYNC_POL to level !SYNC_POL on registered Hsync. Frame start SHALL be the same transition on registered Vsync.
REQ-005 The 12-bit horizontal counter hcnt SHALL load 0 on a line start and otherwise increment, saturating at 4095.
REQ-006 A frame-start edge SHALL set a pending flag. At the next line start, or at the same cycle if both edges coincide, the 11-bit vcnt SHALL load 0, the flag SHALL clear, and oFrameStart SHALL pulse. Otherwise vcnt SHALL increment on each line start, saturating at 2047.
REQ-007 Line length SHALL be hcnt+1 sampled at a line start.
REQ-008 Frame lines SHALL be vcnt+1 sampled at an applied frame start.
REQ-009 The FSM SHALL have four states: IDLE, MEASURE, VERIFY, LOCKED.
- IDLE -> MEASURE on the first applied frame start.
- MEASURE: the first line length of the frame is captured into oLineLen. Any later line of different length restarts MEASURE without an error. The next applied frame start captures oFrameLines and moves to VERIFY.
- VERIFY -> LOCKED at the next applied frame start if every line equalled oLineLen and the frame lines equal oFrameLines. Otherwise VERIFY -> MEASURE.
- LOCKED: a line-length or frame-lines mismatch SHALL set oSyncErr, clear oLocked and move to MEASURE.
REQ-010 hcnt reaching 4095 (no line start) SHALL force IDLE from any state and clear oLocked; this timeout SHALL NOT set oSyncErr.
REQ-011 oLocked SHALL be 1 exactly when the state is LOCKED, registered.
REQ-012 oDE SHALL be 1 only when all of the following hold:
- the state is LOCKED;
- H_BP <= hcnt < H_BP+H_ACTIVE;
- V_BP <= vcnt < V_BP+V_ACTIVE.
REQ-013 When oDE=1: oX = hcnt-H_BP, oY = vcnt-V_BP, oRGB = the registered pixel. oX, oY and oRGB SHALL be 0 otherwise.
REQ-014 Latency from input pins to oRGB/oX/oY/oDE SHALL be exactly 2 Clock cycles, with the pixel sampled at cycle n appearing at n+2.
REQ-015 oFrameStart SHALL have the same 2-cycle latency relative to the triggering edge.
REQ-016 oSyncErr SHALL clear only on Reset.

Reset
REQ-017 Reset SHALL take priority over all other activity, including mid-frame.
REQ-018 On Reset the state SHALL return to IDLE, all counters and the pending flag SHALL clear, and every output SHALL be 0 on the next cycle.
REQ-019 After Reset deasserts, lock SHALL require the full IDLE -> MEASURE -> VERIFY -> LOCKED sequence again.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Lock: 800-cycle lines (Hsync low 96), 525-line frames (Vsync low 2 lines) -> oLocked=1 after the 3rd frame start; oLineLen=800, oFrameLines=525; oDE high for 640x480 per frame.
- Pixel mapping: after lock, drive iRGB=3'b101 only at column 10, row 20 -> oRGB=3'b101 with oX=10, oY=20 two cycles later; oRGB=0 elsewhere.
- Line error: after lock, inject one 801-cycle line -> oLocked=0, oSyncErr=1, state MEASURE; relock two frames later with oSyncErr still 1.
- Timeout: stop Hsync edges while locked -> after 4095 cycles oLocked=0, state IDLE, oSyncErr unchanged.
- Coincident edges: Vsync and Hsync line-start edges on the same cycle -> vcnt=0 and a single oFrameStart pulse.
- Mid-frame reset: Reset for 1 cycle while locked -> all outputs 0 the next cycle; lock returns only after the 3rd subsequent frame start.
